// File: rtl/cve2_obi_arbiter.sv
// Merges the instruction-fetch and data OBI masters onto one OBI master port, routing responses via an ID FIFO.
// Optional macro CVE2_OBI_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of data-over-instr priority.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic        spurious_rvalid_o
);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

  // ID encoding: 0 = instr, 1 = data.
  logic [MaxOutstanding-1:0] r_fifo;
  logic [PtrW-1:0]           r_wptr;
  logic [PtrW-1:0]           r_rptr;
  logic [CntW-1:0]           r_count;
  logic                      r_lock_valid;
  logic                      r_lock_id;
  logic                      r_spurious;

  logic w_full;
  logic w_req;
  logic w_winner;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full = (r_count == CntFull);
  assign w_req  = (instr_req_i | data_req_i) & ~w_full;

`ifdef CVE2_OBI_ARB_ROUND_ROBIN_EN
  logic r_last_id;

  always_comb begin
    w_winner = data_req_i;
    if (r_lock_valid) begin
      w_winner = r_lock_id;
    end else if (instr_req_i && data_req_i) begin
      w_winner = ~r_last_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_id <= 1'b0;
    end else if (w_push) begin
      r_last_id <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = data_req_i;
    if (r_lock_valid) begin
      w_winner = r_lock_id;
    end
  end
`endif

  // OBI handshake: an address phase transfers when mem_req_o & mem_gnt_i; once offered it is held
  // (same winner, same fields) until granted; each transfer gets exactly one rvalid, in order.
  assign w_push = w_req & mem_gnt_i;
  assign w_pop  = mem_rvalid_i & (r_count != '0);
  assign w_head = r_fifo[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_lock_valid <= 1'b0;
      r_lock_id    <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_winner;
        r_wptr         <= (r_wptr == PtrLast) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
      if (w_push) begin
        r_lock_valid <= 1'b0;
      end else if (w_req) begin
        r_lock_valid <= 1'b1;
        r_lock_id    <= w_winner;
      end
      // A response with nothing outstanding (including stale ones after reset) is recorded, not routed.
      if (mem_rvalid_i && (r_count == '0)) begin
        r_spurious <= 1'b1;
      end
    end
  end

  assign mem_req_o   = w_req;
  assign mem_addr_o  = w_winner ? data_addr_i : instr_addr_i;
  assign mem_we_o    = w_winner & data_we_i;
  assign mem_be_o    = w_winner ? data_be_i : 4'hF;
  assign mem_wdata_o = w_winner ? data_wdata_i : '0;

  assign instr_gnt_o = w_push & ~w_winner;
  assign data_gnt_o  = w_push & w_winner;

  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o  = w_pop & w_head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i & instr_rvalid_o;
  assign data_err_o     = mem_err_i & data_rvalid_o;

  assign busy_o            = (r_count != '0);
  assign spurious_rvalid_o = r_spurious;
endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Testbench for cve2_obi_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cve2_obi_arbiter;
  localparam int MAX_OUT = 2;
`ifdef CVE2_OBI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst_n;
  logic instr_req, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr, instr_rdata_o;
  logic data_req, data_gnt_o, data_rvalid_o, data_we, data_err_o;
  logic [3:0] data_be;
  logic [31:0] data_addr, data_wdata, data_rdata_o;
  logic mem_req_o, mem_gnt, mem_rvalid, mem_we_o, mem_err;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic busy_o, spurious_rvalid_o;

  cve2_obi_arbiter #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy_o), .spurious_rvalid_o(spurious_rvalid_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_fail;
  logic [33:0] exp_q[$];        // {id, err, rdata} in response order
  logic [32:0] mem_pend_q[$];   // memory side: {err, rdata} owed for granted transfers
  int mdl_out;
  bit mdl_lock_v, mdl_lock_id, mdl_last, mdl_spur;
  logic [31:0] next_rdata;
  logic next_err;
  bit g_ig, g_dg;
  logic s_mreq, s_ig, s_dg, s_irv, s_drv, s_derr, s_busy, s_spur;
  logic [31:0] s_addr, s_irdata;
  logic [33:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: check DUT against the model mid-cycle, advance model, commit grants at the edge
  task automatic tick();
    bit e_req, e_win, e_push;
    logic [33:0] p_entry;
    @(negedge clk);
    s_mreq = mem_req_o; s_ig = instr_gnt_o; s_dg = data_gnt_o; s_irv = instr_rvalid_o;
    s_drv = data_rvalid_o; s_derr = data_err_o; s_busy = busy_o; s_spur = spurious_rvalid_o;
    s_addr = mem_addr_o; s_irdata = instr_rdata_o;
    e_req = (instr_req || data_req) && (mdl_out < MAX_OUT);
    if (mdl_lock_v) e_win = mdl_lock_id;
    else if (instr_req && data_req) e_win = RR ? !mdl_last : 1'b1;
    else e_win = data_req;
    e_push = e_req && mem_gnt;
    chk("mem_req", 64'(mem_req_o), 64'(e_req));
    chk("instr_gnt", 64'(instr_gnt_o), 64'(e_push && !e_win));
    chk("data_gnt", 64'(data_gnt_o), 64'(e_push && e_win));
    if (e_req) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(e_win ? data_addr : instr_addr));
      chk("mem_we", 64'(mem_we_o), 64'(e_win && data_we));
      chk("mem_be", 64'(mem_be_o), 64'(e_win ? data_be : 4'hF));
      chk("mem_wdata", 64'(mem_wdata_o), 64'(e_win ? data_wdata : 32'h0));
    end
    chk("busy", 64'(busy_o), 64'(mdl_out != 0));
    chk("spurious", 64'(spurious_rvalid_o), 64'(mdl_spur));
    if (!mem_rvalid || mdl_out == 0)
      chk("no_rsp", 64'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 64'(0));
    chk("rdata_pass", {instr_rdata_o, data_rdata_o}, {mem_rdata, mem_rdata});
    if (mem_rvalid) begin
      if (mdl_out > 0) mdl_out--;
      else mdl_spur = 1'b1;
    end
    if (e_push) begin
      mdl_out++;
      mdl_last = e_win;
    end
    if (e_req) begin
      mdl_lock_v = !mem_gnt;
      mdl_lock_id = e_win;
    end
    g_ig = e_push && !e_win;
    g_dg = e_push && e_win;
    p_entry = {e_win, next_err, next_rdata};
    @(posedge clk);
    if (e_push) begin
      exp_q.push_back(p_entry);
      mem_pend_q.push_back(p_entry[32:0]);
    end
    #1;
  endtask

  task automatic respond();
    if (mem_pend_q.size() > 0) begin
      mem_rvalid = 1'b1;
      {mem_err, mem_rdata} = mem_pend_q.pop_front();
    end
  endtask

  task automatic idle_rsp();
    mem_rvalid = 1'b0;
    mem_rdata = $urandom();
    mem_err = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    for (int k = 0; k < 16 && mem_pend_q.size() > 0; k++) begin
      respond();
      tick();
    end
    idle_rsp();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_q.delete();
    mdl_out = 0; mdl_lock_v = 0; mdl_lock_id = 0; mdl_last = 0; mdl_spur = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_spur", 64'(spurious_rvalid_o), 64'(0));
    chk("rst_req", 64'(mem_req_o), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    if (!instr_req || g_ig) begin
      instr_req = ($urandom_range(0, 2) != 0);
      instr_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (!data_req || g_dg) begin
      data_req = ($urandom_range(0, 2) != 0);
      data_addr = $urandom() & 32'hFFFF_FFFC;
      data_we = 1'($urandom_range(0, 1));
      data_be = 4'($urandom_range(0, 15));
      data_wdata = $urandom();
    end
    mem_gnt = ($urandom_range(0, 3) != 0);
    if (mem_pend_q.size() > 0 && $urandom_range(0, 2) != 0) respond();
    else idle_rsp();
    next_rdata = $urandom();
    next_err = ($urandom_range(0, 3) == 0);
  endtask

  // monitor: every routed response must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && (instr_rvalid_o || data_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_unexpected: got rvalid i=%0b d=%0b expected none", instr_rvalid_o, data_rvalid_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_route", 64'({instr_rvalid_o, data_rvalid_o}), 64'(mon_e[33] ? 2'b01 : 2'b10));
        chk("rsp_err", 64'({instr_err_o, data_err_o}), 64'(mon_e[33] ? {1'b0, mon_e[32]} : {mon_e[32], 1'b0}));
        chk("rsp_rdata", 64'(mon_e[33] ? data_rdata_o : instr_rdata_o), 64'(mon_e[31:0]));
      end
    end else if (rst_n && mem_rvalid && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL rsp_missing: got no requester rvalid expected id=%0b", mon_e[33]);
    end
  end

  initial begin
    n_checks = 0; n_fail = 0;
    instr_addr = '0; data_addr = '0; data_we = 1'b0; data_be = 4'h0; data_wdata = '0;
    mem_rdata = '0; mem_err = 1'b0; next_rdata = '0; next_err = 1'b0;
    g_ig = 0; g_dg = 0;
    do_reset();

    // single fetch
    instr_req = 1; instr_addr = 32'h80; mem_gnt = 1; next_rdata = 32'hDEADBEEF; next_err = 0;
    tick();
    chk("t1_gnt", 64'(s_ig), 64'(1));
    chk("t1_addr", 64'(s_addr), 64'h80);
    instr_req = 0; mem_gnt = 0; respond();
    tick();
    chk("t1_irv", 64'(s_irv), 64'(1));
    chk("t1_rdata", 64'(s_irdata), 64'hDEADBEEF);
    chk("t1_drv", 64'(s_drv), 64'(0));
    idle_rsp(); tick();

    // data stalled then locked while instr arrives
    data_req = 1; data_addr = 32'h100; data_we = 1; data_be = 4'h3; data_wdata = 32'h1234_5678; mem_gnt = 0;
    repeat (3) tick();
    instr_req = 1; instr_addr = 32'h200;
    tick();
    chk("lock_addr", 64'(s_addr), 64'h100);
    chk("lock_no_gnt", 64'({s_ig, s_dg}), 64'(0));
    mem_gnt = 1;
    tick();
    chk("lock_dgnt", 64'(s_dg), 64'(1));
    chk("lock_daddr", 64'(s_addr), 64'h100);
    data_req = 0;
    tick();
    chk("lock_ignt", 64'(s_ig), 64'(1));
    chk("lock_iaddr", 64'(s_addr), 64'h200);
    drain();

    // instr locked; higher-priority data must not steal the stalled address phase
    instr_req = 1; instr_addr = 32'h300; mem_gnt = 0;
    tick();
    data_req = 1; data_addr = 32'h400; data_we = 0;
    tick();
    chk("rlock_addr", 64'(s_addr), 64'h300);
    mem_gnt = 1;
    tick();
    chk("rlock_ignt", 64'(s_ig), 64'(1));
    instr_req = 0;
    tick();
    chk("rlock_dgnt", 64'(s_dg), 64'(1));
    drain();

    // full FIFO
    instr_req = 1; instr_addr = 32'h500; mem_gnt = 1;
    tick();
    instr_addr = 32'h504;
    tick();
    instr_addr = 32'h508;
    tick();
    chk("full_req", 64'(s_mreq), 64'(0));
    chk("full_busy", 64'(s_busy), 64'(1));
    respond();
    tick();
    chk("full_req_pop", 64'(s_mreq), 64'(0));
    idle_rsp();
    tick();
    chk("full_req_after", 64'(s_mreq), 64'(1));
    chk("full_gnt_after", 64'(s_ig), 64'(1));
    drain();

    // interleaved routing
    instr_req = 1; instr_addr = 32'h600; mem_gnt = 1; next_err = 0;
    tick();
    chk("il_ignt", 64'(s_ig), 64'(1));
    instr_req = 0; data_req = 1; data_addr = 32'h700; data_we = 0; next_err = 1;
    tick();
    chk("il_dgnt", 64'(s_dg), 64'(1));
    data_req = 0; mem_gnt = 0; respond();
    tick();
    chk("il_irv", 64'({s_irv, s_drv}), 64'(2'b10));
    respond();
    tick();
    chk("il_drv", 64'({s_irv, s_drv}), 64'(2'b01));
    chk("il_derr", 64'(s_derr), 64'(1));
    next_err = 0;
    drain();

    // arbitration under continuous contention
    do_reset();
    instr_req = 1; data_req = 1; mem_gnt = 1; instr_addr = 32'h800; data_addr = 32'h900;
    for (int i = 0; i < 4; i++) begin
      if (mem_pend_q.size() > 0) respond();
      else idle_rsp();
      tick();
`ifdef CVE2_OBI_ARB_ROUND_ROBIN_EN
      chk("rr_dgnt", 64'(s_dg), 64'(i % 2 == 0));
      chk("rr_ignt", 64'(s_ig), 64'(i % 2 == 1));
`else
      chk("fp_dgnt", 64'(s_dg), 64'(1));
      chk("fp_ignt", 64'(s_ig), 64'(0));
`endif
    end
    drain();

    // spurious response
    mem_rvalid = 1; mem_rdata = 32'hBAD0_0001; mem_err = 1;
    tick();
    chk("sp_rv", 64'({s_irv, s_drv}), 64'(0));
    idle_rsp();
    tick();
    chk("sp_flag", 64'(s_spur), 64'(1));
    repeat (3) tick();
    chk("sp_sticky", 64'(s_spur), 64'(1));
    do_reset();

    // reset with transfers outstanding, late responses afterwards
    instr_req = 1; instr_addr = 32'hA00; mem_gnt = 1;
    tick();
    instr_addr = 32'hA04;
    tick();
    do_reset();
    respond();
    tick();
    chk("late_rv", 64'({s_irv, s_drv}), 64'(0));
    idle_rsp();
    tick();
    chk("late_spur", 64'(s_spur), 64'(1));
    mem_pend_q.delete();
    do_reset();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_drive();
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cve2_obi_arbiter.md
Name: cve2_obi_arbiter

Overview:
- Merges the core's separate instruction-fetch and data OBI master ports into one OBI master port toward a single-ported memory or interconnect.
- Sits directly downstream of the core top-level's instr_* / data_* interfaces.
- Arbitrates address phases, holds the chosen request stable until granted, and tracks outstanding transactions in an ID FIFO so each response returns to the requester that issued it.

Parameters:
- MaxOutstanding, 2, depth of the response-routing ID FIFO (legal range 1..8); maximum granted-but-unanswered transactions.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch address
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error
- mem_req_o  out  1  merged request
- mem_gnt_i  in  1  merged grant
- mem_rvalid_i  in  1  merged response valid
- mem_we_o  out  1  merged write enable
- mem_be_o  out  4  merged byte enables
- mem_addr_o  out  32  merged address
- mem_wdata_o  out  32  merged write data
- mem_rdata_i  in  32  merged read data
- mem_err_i  in  1  merged error
- busy_o  out  1  outstanding count non-zero
- spurious_rvalid_o  out  1  sticky: rvalid arrived with empty FIFO

Behaviour:
- State:
  - ID FIFO, MaxOutstanding entries of 1 bit (0 = instr, 1 = data).
  - Count register.
  - lock_valid / lock_id registers.
  - spurious flag.
  - Reset clears all of them.
  - Reset values: busy_o = 0, spurious_rvalid_o = 0; gnt/rvalid outputs are 0 whenever inputs request nothing.
- full = (count == MaxOutstanding).
- mem_req_o = (instr_req_i | data_req_i) & ~full. When full, no request is forwarded even if mem_rvalid_i pops that cycle; the pop frees the slot for the next cycle.
- Winner selection:
  - If lock_valid, winner = lock_id.
  - Else fixed priority: data over instr (see optional feature).
- Lock: if mem_req_o & ~mem_gnt_i, set lock_valid and lock_id = winner. Clear on mem_req_o & mem_gnt_i. This guarantees OBI address-phase stability.
- mem_we_o / mem_be_o / mem_wdata_o:
  - Driven from the data port when winner = data.
  - When winner = instr: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- mem_addr_o is muxed from the winner's address.
- Grants: instr_gnt_o = mem_gnt_i & mem_req_o & (winner == instr). data_gnt_o is analogous. The grant path is purely combinational, zero latency.
- Push: winner ID is pushed on mem_req_o & mem_gnt_i.
- Pop: on mem_rvalid_i with count > 0.
  - Response routed by head ID: instr_rvalid_o = mem_rvalid_i & head == 0; data_rvalid_o is analogous.
  - Writes also receive an rvalid (OBI).
- Push and pop in the same cycle: count unchanged, FIFO pointers both advance and wrap modulo MaxOutstanding.
- Response in the same cycle as its own grant is illegal for the memory; it is treated as a response to the previous head only.
- mem_rvalid_i with count == 0: no requester rvalid asserted; spurious_rvalid_o set and held until reset.
- instr_rdata_o / data_rdata_o = mem_rdata_i unconditionally. instr_err_o / data_err_o = mem_err_i gated by the respective rvalid.
- busy_o = (count != 0), registered state only.
- Reset asserted mid-transaction:
  - Outstanding IDs and the lock are discarded.
  - Late responses after reset release set spurious_rvalid_o.
- Requester dropping req before grant while locked is an OBI violation; the lock is still held until a grant is seen.

Optional Feature:
- Macro CVE2_OBI_ARB_ROUND_ROBIN_EN.
- Defined:
  - Unlocked winner selection is round-robin, via a 1-bit last_id register updated on every grant (reset 0 = instr last, so data wins the first tie).
  - When both request, the port not granted last wins.
- Undefined: fixed priority, data over instr; no last_id register.
- Lock behaviour is identical in both builds.

Test Plan:
- Single fetch: instr_req_i = 1, addr 0x80, mem_gnt_i = 1 same cycle → instr_gnt_o = 1. Next cycle mem_rvalid_i = 1, rdata 0xDEADBEEF → instr_rvalid_o = 1, instr_rdata_o = 0xDEADBEEF, data_rvalid_o = 0.
- Stall lock: data_req_i at 0x100 with mem_gnt_i = 0 for 3 cycles, then instr_req_i rises → mem_addr_o stays 0x100 until grant. Data granted first, then instr granted.
- Full FIFO: MaxOutstanding = 2, two grants without rvalid → mem_req_o = 0 while requests pending, busy_o = 1. One rvalid → mem_req_o = 1 the following cycle.
- Interleaved routing: grants in order instr, data; responses return with err = 0 then err = 1 → instr_rvalid_o then data_rvalid_o with data_err_o = 1.
- Spurious: mem_rvalid_i = 1 with count 0 → no requester rvalid, spurious_rvalid_o = 1 sticky until rst_ni low.
- Round-robin (macro on): both req continuously, mem_gnt_i = 1 → grants alternate data, instr, data, instr. Macro off → data granted every cycle, instr starved.
